codec_init_sequencer: RTL and testbench

- Brings the audio CODEC from reset to active after power-up or on request.
- Walks a fixed table of 12 register writes: 7-bit register address, 9-bit data.
- Issues each write to the existing CODEC I2C controller over a request/accept/done handshake, and inserts the required power-up and activate delays.
- Sits inside the CODEC unit between the AXI-lite register block (start/status) and the I2C controller.

---
 rtl/codec_init_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_codec_init_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer: brings the audio CODEC out of reset by walking a
// fixed 12-entry register table through the I2C controller handshake,
// with a power-up delay before the first write and an activate delay
// before entry 10.
// Optional build macro: CODEC_INIT_RETRY_EN adds per-entry retries on
// NACK/timeout (up to MAX_RETRIES); without it any failure aborts.
module codec_init_sequencer #(
    parameter logic [6:0] DEV_ADDR        = 7'h1A,
    parameter int         POWERUP_CYCLES  = 125000,
    parameter int         ACTIVATE_CYCLES = 12500,
    parameter int         TIMEOUT_CYCLES  = 100000,
    parameter int         MAX_RETRIES     = 3
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       start,
    output logic       i2c_req,
    input  logic       i2c_accept,
    input  logic       i2c_done,
    input  logic       i2c_nack,
    output logic [6:0] i2c_dev_addr,
    output logic [6:0] i2c_reg_addr,
    output logic [8:0] i2c_reg_data,
    output logic       busy,
    output logic       init_done,
    output logic       init_error,
    output logic [3:0] cur_index,
    output logic [7:0] fail_count
);

    // One shared down-counter serves all three waits; they never overlap.
    localparam int CNT_MAX_PA = (POWERUP_CYCLES > ACTIVATE_CYCLES) ? POWERUP_CYCLES : ACTIVATE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_PA > TIMEOUT_CYCLES) ? CNT_MAX_PA : TIMEOUT_CYCLES;
    localparam int CNT_W      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_PWR_WAIT, S_ISSUE, S_WAIT_DONE, S_NEXT,
        S_ACT_WAIT, S_FAIL, S_DONE, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       fc_q, fc_d;
    logic [15:0]      entry;

`ifdef CODEC_INIT_RETRY_EN
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RTY_W-1:0] rty_q, rty_d;
`endif

    // Init table: {7-bit register address, 9-bit data}.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    table_entry = {7'd15, 9'h000};
            4'd1:    table_entry = {7'd6,  9'h030};
            4'd2:    table_entry = {7'd0,  9'h017};
            4'd3:    table_entry = {7'd1,  9'h017};
            4'd4:    table_entry = {7'd2,  9'h079};
            4'd5:    table_entry = {7'd3,  9'h079};
            4'd6:    table_entry = {7'd4,  9'h010};
            4'd7:    table_entry = {7'd5,  9'h000};
            4'd8:    table_entry = {7'd7,  9'h00A};
            4'd9:    table_entry = {7'd8,  9'h000};
            4'd10:   table_entry = {7'd9,  9'h001};
            4'd11:   table_entry = {7'd6,  9'h020};
            default: table_entry = 16'h0000;
        endcase
    endfunction

    assign entry        = table_entry(idx_q);
    assign i2c_dev_addr = DEV_ADDR;
    assign busy         = busy_q;
    assign init_done    = done_q;
    assign init_error   = err_q;
    assign cur_index    = idx_q;
    assign fail_count   = fc_q;

    // State and status registers; reset wins over everything.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fc_q    <= '0;
`ifdef CODEC_INIT_RETRY_EN
            rty_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fc_q    <= fc_d;
`ifdef CODEC_INIT_RETRY_EN
            rty_q   <= rty_d;
`endif
        end
    end

    // Next-state and handshake outputs; address/data only driven while requesting
    // so they read 0 outside a request and hold steady until accept.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        fc_d         = fc_q;
        i2c_req      = 1'b0;
        i2c_reg_addr = 7'd0;
        i2c_reg_data = 9'd0;
`ifdef CODEC_INIT_RETRY_EN
        rty_d        = rty_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PWR_WAIT;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = 4'd0;
                    cnt_d   = CNT_W'(POWERUP_CYCLES);
`ifdef CODEC_INIT_RETRY_EN
                    rty_d   = '0;
`endif
                end
            end
            S_PWR_WAIT, S_ACT_WAIT: begin
                if (cnt_q == '0) state_d = S_ISSUE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ISSUE: begin
                i2c_req      = 1'b1;
                i2c_reg_addr = entry[15:9];
                i2c_reg_data = entry[8:0];
                if (i2c_accept) begin
                    state_d = S_WAIT_DONE;
                    cnt_d   = CNT_W'(TIMEOUT_CYCLES);
                end
            end
            S_WAIT_DONE: begin
                // A done coinciding with expiry is checked first, so it succeeds.
                if (i2c_done && !i2c_nack)      state_d = S_NEXT;
                else if (i2c_done || cnt_q == '0) state_d = S_FAIL;
                else                            cnt_d   = cnt_q - 1'b1;
            end
            S_NEXT: begin
`ifdef CODEC_INIT_RETRY_EN
                rty_d = '0;
`endif
                if (idx_q == 4'd11) begin
                    state_d = S_DONE;
                end else if (idx_q == 4'd9) begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = CNT_W'(ACTIVATE_CYCLES);
                    state_d = S_ACT_WAIT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_FAIL: begin
                fc_d    = (fc_q == 8'hFF) ? fc_q : fc_q + 1'b1;
                state_d = S_ERROR;
`ifdef CODEC_INIT_RETRY_EN
                if (rty_q < RTY_W'(MAX_RETRIES)) begin
                    rty_d   = rty_q + 1'b1;
                    state_d = S_ISSUE;
                end
`endif
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Directed bench for codec_init_sequencer with a small behavioural I2C
// controller model (configurable accept delay, NACK and missing done).
module tb_codec_init_sequencer;

    localparam int P     = 20;
    localparam int A     = 30;
    localparam int T     = 60;
    localparam int MR    = 3;
    localparam int DDLY  = 20;

    logic       board_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       i2c_req, i2c_accept, i2c_done, i2c_nack;
    logic [6:0] i2c_dev_addr, i2c_reg_addr;
    logic [8:0] i2c_reg_data;
    logic       busy, init_done, init_error;
    logic [3:0] cur_index;
    logic [7:0] fail_count;

    codec_init_sequencer #(
        .DEV_ADDR(7'h1A), .POWERUP_CYCLES(P), .ACTIVATE_CYCLES(A),
        .TIMEOUT_CYCLES(T), .MAX_RETRIES(MR)
    ) dut (
        .board_clk(board_clk), .reset(reset), .start(start),
        .i2c_req(i2c_req), .i2c_accept(i2c_accept), .i2c_done(i2c_done),
        .i2c_nack(i2c_nack), .i2c_dev_addr(i2c_dev_addr),
        .i2c_reg_addr(i2c_reg_addr), .i2c_reg_data(i2c_reg_data),
        .busy(busy), .init_done(init_done), .init_error(init_error),
        .cur_index(cur_index), .fail_count(fail_count)
    );

    always #5 board_clk = ~board_clk;

    int cyc = 0;
    always @(posedge board_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference table
    logic [6:0] ref_addr [12] = '{7'd15, 7'd6, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd7, 7'd8, 7'd9, 7'd6};
    logic [8:0] ref_data [12] = '{9'h000, 9'h030, 9'h017, 9'h017, 9'h079, 9'h079, 9'h010, 9'h000, 9'h00A, 9'h000, 9'h001, 9'h020};

    function automatic int tbl_idx(input logic [6:0] a, input logic [8:0] d);
        tbl_idx = 15;
        for (int i = 0; i < 12; i++)
            if (ref_addr[i] == a && ref_data[i] == d) tbl_idx = i;
    endfunction

    // Controller model configuration (written by main process only)
    int acc_dly_idx = -1;
    int acc_dly     = 0;
    int nack_idx    = -1;
    int nack_n      = 0;
    bit no_done     = 1'b0;

    // Controller model state and transaction log (written by model only)
    int         n_txn = 0;
    int         t_idx [256];
    int         t_cyc [256];
    int         d_cyc [256];
    logic [6:0] t_addr [256];
    logic [8:0] t_data [256];
    int         issue_cnt [16];
    int         ph = 0, w = 0, cur = 0;
    int         stab_bad = 0, stab_n = 0, bad_drop = 0;

    initial begin
        i2c_accept = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
        for (int i = 0; i < 16; i++) issue_cnt[i] = 0;
        forever begin
            @(negedge board_clk);
            i2c_accept = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
            if (reset) begin
                ph = 0;
                for (int i = 0; i < 16; i++) issue_cnt[i] = 0;
            end else begin
                case (ph)
                    0: if (i2c_req) begin
                        cur = tbl_idx(i2c_reg_addr, i2c_reg_data);
                        t_idx[n_txn] = cur; t_cyc[n_txn] = cyc; d_cyc[n_txn] = 0;
                        t_addr[n_txn] = i2c_reg_addr; t_data[n_txn] = i2c_reg_data;
                        n_txn++;
                        issue_cnt[cur]++;
                        if (cur == acc_dly_idx && acc_dly > 0) begin
                            ph = 1; w = acc_dly;
                        end else begin
                            i2c_accept = 1'b1; ph = 2; w = DDLY;
                        end
                    end
                    1: begin
                        stab_n++;
                        if (!i2c_req || i2c_reg_addr != t_addr[n_txn-1] || i2c_reg_data != t_data[n_txn-1])
                            stab_bad++;
                        w--;
                        if (w == 0) begin i2c_accept = 1'b1; ph = 2; w = DDLY; end
                    end
                    default: begin
                        if (w == DDLY && i2c_req) bad_drop++;
                        w--;
                        if (w == 0) begin
                            ph = 0;
                            if (!no_done) begin
                                i2c_done = 1'b1;
                                i2c_nack = (cur == nack_idx && issue_cnt[cur] <= nack_n);
                                d_cyc[n_txn-1] = cyc;
                            end
                        end
                    end
                endcase
            end
        end
    end

    int st_cyc = 0;

    task automatic do_reset();
        @(negedge board_clk); reset = 1'b1;
        repeat (2) @(negedge board_clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge board_clk); start = 1'b1; st_cyc = cyc + 1;
        @(negedge board_clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin @(negedge board_clk); n++; end
        chk({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    int b, cnt4, cnt6, el;

    initial begin
        // Reset state
        repeat (3) @(negedge board_clk);
        chk("rst_req",   {31'd0, i2c_req}, 32'd0);
        chk("rst_dev",   {25'd0, i2c_dev_addr}, 32'h1A);
        chk("rst_raddr", {25'd0, i2c_reg_addr}, 32'd0);
        chk("rst_rdata", {23'd0, i2c_reg_data}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, init_done}, 32'd0);
        chk("rst_err",   {31'd0, init_error}, 32'd0);
        chk("rst_idx",   {28'd0, cur_index}, 32'd0);
        chk("rst_fc",    {24'd0, fail_count}, 32'd0);
        reset = 1'b0;

        // Ideal controller
        b = n_txn;
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_idle("ideal", 2000);
        chk("ideal_ntxn", n_txn - b, 12);
        chk("pwr_latency", t_cyc[b] - st_cyc, P + 1);
        for (int i = 0; i < 12; i++) chk($sformatf("order%0d", i), t_idx[b+i], i);
        chk("e2_addr", {25'd0, t_addr[b+2]}, 32'h00);
        chk("e2_data", {23'd0, t_data[b+2]}, 32'h017);
        chk("gap_normal", t_cyc[b+3] - d_cyc[b+2], 2);
        chk("gap_activate", (t_cyc[b+10] - d_cyc[b+9]) >= A, 1);
        chk("ideal_done", {31'd0, init_done}, 32'd1);
        chk("ideal_err",  {31'd0, init_error}, 32'd0);
        chk("ideal_fc",   {24'd0, fail_count}, 32'd0);
        chk("ideal_idx",  {28'd0, cur_index}, 32'd11);
        chk("req_drop", bad_drop, 0);

        // Accept delayed 50 cycles on entry 4
        do_reset();
        acc_dly_idx = 4; acc_dly = 50;
        b = n_txn;
        pulse_start();
        wait_idle("accdly", 3000);
        cnt4 = 0;
        for (int i = b; i < n_txn; i++) if (t_idx[i] == 4) cnt4++;
        chk("accdly_e4_once", cnt4, 1);
        chk("accdly_hold_cycles", stab_n, 50);
        chk("accdly_stable", stab_bad, 0);
        chk("accdly_ntxn", n_txn - b, 12);
        chk("accdly_done", {31'd0, init_done}, 32'd1);
        acc_dly_idx = -1; acc_dly = 0;

        // NACK on entry 6
        do_reset();
        nack_idx = 6;
`ifdef CODEC_INIT_RETRY_EN
        nack_n = 2;
`else
        nack_n = 1;
`endif
        b = n_txn;
        pulse_start();
        wait_idle("nack", 3000);
        repeat (200) @(negedge board_clk);
        cnt6 = 0;
        for (int i = b; i < n_txn; i++) if (t_idx[i] == 6) cnt6++;
`ifdef CODEC_INIT_RETRY_EN
        chk("retry_e6_issues", cnt6, 3);
        chk("retry_fc",   {24'd0, fail_count}, 32'd2);
        chk("retry_done", {31'd0, init_done}, 32'd1);
        chk("retry_err",  {31'd0, init_error}, 32'd0);
        chk("retry_ntxn", n_txn - b, 14);
`else
        chk("nack_err",   {31'd0, init_error}, 32'd1);
        chk("nack_done",  {31'd0, init_done}, 32'd0);
        chk("nack_idx",   {28'd0, cur_index}, 32'd6);
        chk("nack_fc",    {24'd0, fail_count}, 32'd1);
        chk("nack_no_more_req", n_txn - b, 7);
        chk("nack_e6_issues", cnt6, 1);
`endif
        nack_idx = -1; nack_n = 0;

        // Done never returned on entry 0
        do_reset();
        no_done = 1'b1;
        b = n_txn;
        pulse_start();
        wait_idle("tmo", 2000);
        el = 0;
        while (!init_error && el < 1000) begin @(negedge board_clk); el++; end
        el = cyc - t_cyc[b];
        chk("tmo_err", {31'd0, init_error}, 32'd1);
        chk("tmo_idx", {28'd0, cur_index}, 32'd0);
        chk("tmo_elapsed_min", el >= T, 1);
`ifndef CODEC_INIT_RETRY_EN
        chk("tmo_elapsed_max", el <= T + 4, 1);
        chk("tmo_fc", {24'd0, fail_count}, 32'd1);
`endif
        no_done = 1'b0;

        // Reset during WAIT_DONE of entry 5, then restart
        do_reset();
        b = n_txn;
        pulse_start();
        el = 0;
        while (n_txn - b < 6 && el < 2000) begin @(negedge board_clk); el++; end
        chk("mid_reach_e5", t_idx[n_txn-1], 5);
        repeat (5) @(negedge board_clk);
        reset = 1'b1;
        @(negedge board_clk);
        chk("mid_rst_req",  {31'd0, i2c_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_idx",  {28'd0, cur_index}, 32'd0);
        chk("mid_rst_dev",  {25'd0, i2c_dev_addr}, 32'h1A);
        chk("mid_rst_raddr", {25'd0, i2c_reg_addr}, 32'd0);
        chk("mid_rst_done", {31'd0, init_done}, 32'd0);
        chk("mid_rst_err",  {31'd0, init_error}, 32'd0);
        chk("mid_rst_fc",   {24'd0, fail_count}, 32'd0);
        repeat (30) @(negedge board_clk);
        reset = 1'b0;
        b = n_txn;
        pulse_start();
        el = 0;
        while (n_txn - b < 4 && el < 2000) begin @(negedge board_clk); el++; end
        pulse_start();
        chk("busy_start_idx", {28'd0, cur_index}, 32'd3);
        wait_idle("restart", 3000);
        chk("restart_ntxn", n_txn - b, 12);
        for (int i = 0; i < 12; i++) chk($sformatf("restart_order%0d", i), t_idx[b+i], i);
        chk("restart_done", {31'd0, init_done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
